plic_target_arbiter: RTL and testbench

- Per-hart PLIC target core. Collects one-cycle pending pulses from the per-source gateways and holds them in a pending register.
- Selects the highest-priority eligible source and drives the external interrupt line.
- Implements the claim/complete protocol. On complete it emits a one-cycle complete_id pulse back to all gateways.
- Sits between the gateway array and the PLIC register-file/bus slave, which supplies priority, enable and threshold and issues the claim/complete strobes.

---
 rtl/plic_target_arbiter.sv | 164 ++++++++++++++++
 tb/tb_plic_target_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_target_arbiter.sv
// -----------------------------------------------------------------------------
// plic_target_arbiter
//
// Per-hart PLIC target core. Latches one-cycle pending pulses from the source
// gateways, picks the highest-priority eligible source (ties -> lowest ID),
// drives the hart's external interrupt line and runs the claim/complete
// handshake. A completed ID is broadcast to the gateways as a one-cycle pulse.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   pending_set    per-source one-cycle pending pulse (bit 0 ignored)
//   src_priority   flat priority array, slice i = source i (slice 0 ignored)
//   enable         per-source enable for this target (bit 0 ignored)
//   threshold      target priority threshold
//   claim_req      one-cycle claim strobe
//   claim_id       claimed ID, valid combinationally in the claim_req cycle
//   complete_req   one-cycle complete strobe
//   complete_wr_id ID written together with complete_req
//   complete_id    completed ID for one cycle, otherwise 0
//   irq            external interrupt request
//   pending_q      pending register read-back (bit 0 always 0)
// -----------------------------------------------------------------------------
module plic_target_arbiter #(
    parameter int NUM_SOURCES = 31,
    parameter int PRIO_WIDTH  = 3,
    parameter int ID_WIDTH    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_SOURCES:0]                  pending_set,
    input  logic [(NUM_SOURCES+1)*PRIO_WIDTH-1:0] src_priority,
    input  logic [NUM_SOURCES:0]                  enable,
    input  logic [PRIO_WIDTH-1:0]                 threshold,
    input  logic                                  claim_req,
    output logic [ID_WIDTH-1:0]                   claim_id,
    input  logic                                  complete_req,
    input  logic [ID_WIDTH-1:0]                   complete_wr_id,
    output logic [ID_WIDTH-1:0]                   complete_id,
    output logic                                  irq,
    output logic [NUM_SOURCES:0]                  pending_q
);

    // ARB: normal operation. SETTLE: the single cycle after a successful
    // claim, during which best_id_reg still reflects the pre-claim state.
    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_SOURCES:0]  pending_reg,    pending_next;
    logic [NUM_SOURCES:0]  in_service_reg, in_service_next;
    logic [ID_WIDTH-1:0]   best_id_reg,    best_id_next;
    logic [PRIO_WIDTH-1:0] best_prio_reg,  best_prio_next;
    logic                  irq_reg,        irq_next;
    logic [ID_WIDTH-1:0]   complete_id_reg, complete_id_next;

    logic [PRIO_WIDTH-1:0] prio [1:NUM_SOURCES];
    logic [NUM_SOURCES:0]  eligible;
    logic [NUM_SOURCES:0]  claim_hit;     // one-hot of the successfully claimed ID
    logic [NUM_SOURCES:0]  complete_hit;  // one-hot decode of complete_wr_id
    logic                  claim_ok;
    logic                  complete_ok;

    // Index 0 is the "no interrupt" ID and carries no state.
    assign eligible[0]     = 1'b0;
    assign claim_hit[0]    = 1'b0;
    assign complete_hit[0] = 1'b0;

    generate
        for (genvar gi = 1; gi <= NUM_SOURCES; gi++) begin : g_src
            assign prio[gi]         = src_priority[gi*PRIO_WIDTH +: PRIO_WIDTH];
            // Priority 0 can never exceed threshold, so it is never eligible.
            assign eligible[gi]     = pending_reg[gi] & enable[gi] & ~in_service_reg[gi]
                                      & (prio[gi] > threshold);
            assign claim_hit[gi]    = claim_ok & (claim_id == ID_WIDTH'(gi));
            // Decoding only 1..NUM_SOURCES makes out-of-range IDs miss everything.
            assign complete_hit[gi] = (complete_wr_id == ID_WIDTH'(gi));
        end
    endgenerate

    // Claims during SETTLE read 0 so the stale best_id cannot be claimed twice.
    assign claim_id    = (claim_req && (state_reg == ST_ARB)) ? best_id_reg : '0;
    assign claim_ok    = (claim_id != '0);
    assign complete_ok = complete_req & (|(complete_hit & in_service_reg));

    // Max over eligible sources. Ascending scan with strict '>' keeps the
    // lowest ID on a priority tie.
    always_comb begin
        best_id_next   = '0;
        best_prio_next = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            if (eligible[i] && (prio[i] > best_prio_next)) begin
                best_id_next   = ID_WIDTH'(i);
                best_prio_next = prio[i];
            end
        end
    end

    // FSM next state and derived register inputs.
    always_comb begin
        state_next       = state_reg;
        pending_next     = pending_reg;
        in_service_next  = in_service_reg;
        irq_next         = 1'b0;
        complete_id_next = '0;

        case (state_reg)
            ST_ARB:    if (claim_ok) state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_ARB;
            default:   state_next = ST_ARB;
        endcase

        // Set after clear so a new pulse on the claimed source is not lost.
        pending_next = (pending_reg & ~claim_hit) | {pending_set[NUM_SOURCES:1], 1'b0};

        // Complete clears first, claim sets afterwards: claim wins on the same ID.
        in_service_next = (in_service_reg & ~(complete_hit & {(NUM_SOURCES+1){complete_ok}}))
                          | claim_hit;

        // irq is held low for the settle cycle.
        irq_next = (best_id_next != '0) && (state_next == ST_ARB);

        if (complete_ok) complete_id_next = complete_wr_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg     <= '0;
            in_service_reg  <= '0;
            best_id_reg     <= '0;
            best_prio_reg   <= '0;
            irq_reg         <= 1'b0;
            complete_id_reg <= '0;
        end else begin
            pending_reg     <= pending_next;
            in_service_reg  <= in_service_next;
            best_id_reg     <= best_id_next;
            best_prio_reg   <= best_prio_next;
            irq_reg         <= irq_next;
            complete_id_reg <= complete_id_next;
        end
    end

    assign pending_q   = pending_reg;
    assign irq         = irq_reg;
    assign complete_id = complete_id_reg;

    // Bits that exist only for port symmetry, plus the registered winning
    // priority kept for debug visibility.
    logic unused_ok;
    assign unused_ok = ^{pending_set[0], enable[0], src_priority[PRIO_WIDTH-1:0], best_prio_reg};

endmodule

// File: tb/tb_plic_target_arbiter.sv
module tb_plic_target_arbiter;

    localparam int NS = 31;
    localparam int PW = 3;
    localparam int IW = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NS:0]            pending_set;
    logic [(NS+1)*PW-1:0]   src_priority;
    logic [NS:0]            enable;
    logic [PW-1:0]          threshold;
    logic                   claim_req;
    logic [IW-1:0]          claim_id;
    logic                   complete_req;
    logic [IW-1:0]          complete_wr_id;
    logic [IW-1:0]          complete_id;
    logic                   irq;
    logic [NS:0]            pending_q;

    plic_target_arbiter #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pending_set    (pending_set),
        .src_priority   (src_priority),
        .enable         (enable),
        .threshold      (threshold),
        .claim_req      (claim_req),
        .claim_id       (claim_id),
        .complete_req   (complete_req),
        .complete_wr_id (complete_wr_id),
        .complete_id    (complete_id),
        .irq            (irq),
        .pending_q      (pending_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain per-source flags and integers.
    bit m_pend  [0:NS];
    bit m_insvc [0:NS];
    int m_best;
    bit m_irq;
    int m_cid;
    bit m_settle;

    function automatic int prio_of(int i);
        return int'(src_priority[i*PW +: PW]);
    endfunction

    // Highest priority first, then lowest ID among that priority.
    function automatic int model_winner();
        for (int p = (1 << PW) - 1; p > int'(threshold); p--)
            for (int i = 1; i <= NS; i++)
                if (m_pend[i] && enable[i] && !m_insvc[i] && prio_of(i) == p)
                    return i;
        return 0;
    endfunction

    function automatic int model_claim();
        return (claim_req && !m_settle) ? m_best : 0;
    endfunction

    function automatic logic [NS:0] model_pend_vec();
        logic [NS:0] v;
        for (int i = 0; i <= NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= NS; i++) begin
            m_pend[i]  = 1'b0;
            m_insvc[i] = 1'b0;
        end
        m_best = 0; m_irq = 1'b0; m_cid = 0; m_settle = 1'b0;
    endtask

    // Advance one clock: evaluate the model on the current inputs, commit at
    // the edge, then drop the one-cycle strobes 1 time unit later.
    task automatic tick();
        int c, w, id;
        bit acc;
        logic [NS:0] ps;
        c   = model_claim();
        w   = model_winner();
        id  = int'(complete_wr_id);
        acc = complete_req && id >= 1 && id <= NS && m_insvc[id];
        ps  = pending_set;
        @(posedge clk);
        if (acc) m_insvc[id] = 1'b0;
        if (c != 0) begin
            m_insvc[c] = 1'b1;
            m_pend[c]  = 1'b0;
        end
        for (int i = 1; i <= NS; i++) if (ps[i]) m_pend[i] = 1'b1;
        m_best   = w;
        m_irq    = (w != 0) && (c == 0);
        m_settle = (c != 0);
        m_cid    = acc ? id : 0;
        #1;
        pending_set  = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
    endtask

    task automatic set_prio(input int i, input int p);
        src_priority[i*PW +: PW] = PW'(p);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pending_set = '0; src_priority = '0; enable = '0; threshold = '0;
        claim_req = 1'b0; complete_req = 1'b0; complete_wr_id = '0;
        model_reset();
        #2;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (pending_q !== '0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending_q); end
        n_cmp++; if (complete_id !== '0) begin n_fail++; $display("FAIL reset_complete_id: got %0d want 0", complete_id); end
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== '0) begin n_fail++; $display("FAIL reset_claim_id: got %0d want 0", claim_id); end
        claim_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_idle_irq: got %b want 0", irq); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        threshold = 0; set_prio(3, 2); enable[3] = 1'b1;
        pending_set[3] = 1'b1; tick();
        n_cmp++; if (pending_q[3] !== 1'b1) begin n_fail++; $display("FAIL single_pend_t1: got %b want 1", pending_q[3]); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_t1: got %b want 0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_t2: got %b want 1", irq); end
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(3)) begin n_fail++; $display("FAIL single_claim: got %0d want 3", claim_id); end
        tick();
        n_cmp++; if (pending_q[3] !== 1'b0) begin n_fail++; $display("FAIL single_pend_clr: got %b want 0", pending_q[3]); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clr: got %b want 0", irq); end
        complete_req = 1'b1; complete_wr_id = IW'(3); tick();
        n_cmp++; if (complete_id !== IW'(3)) begin n_fail++; $display("FAIL single_complete: got %0d want 3", complete_id); end
        tick();
        n_cmp++; if (complete_id !== '0) begin n_fail++; $display("FAIL single_complete_len: got %0d want 0", complete_id); end
        $display("test_single done");
    endtask

    task automatic test_priority_tie();
        int exp_a [4] = '{4, 2, 7, 0};
        set_prio(2, 5); set_prio(7, 5); set_prio(4, 6);
        enable[2] = 1'b1; enable[4] = 1'b1; enable[7] = 1'b1;
        // Round 1: no complete between claims.
        pending_set[2] = 1'b1; pending_set[4] = 1'b1; pending_set[7] = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            claim_req = 1'b1; #1;
            n_cmp++; if (claim_id !== IW'(exp_a[k])) begin n_fail++; $display("FAIL tie_claim_nocomp[%0d]: got %0d want %0d", k, claim_id, exp_a[k]); end
            tick(); tick();
        end
        for (int k = 0; k < 3; k++) begin
            complete_req = 1'b1; complete_wr_id = IW'(exp_a[k]); tick();
            n_cmp++; if (complete_id !== IW'(exp_a[k])) begin n_fail++; $display("FAIL tie_complete[%0d]: got %0d want %0d", k, complete_id, exp_a[k]); end
        end
        // Round 2: complete each source right after its claim.
        pending_set[2] = 1'b1; pending_set[4] = 1'b1; pending_set[7] = 1'b1;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            claim_req = 1'b1; #1;
            n_cmp++; if (claim_id !== IW'(exp_a[k])) begin n_fail++; $display("FAIL tie_claim_comp[%0d]: got %0d want %0d", k, claim_id, exp_a[k]); end
            tick();
            complete_req = 1'b1; complete_wr_id = IW'(exp_a[k]); tick();
            n_cmp++; if (complete_id !== IW'(exp_a[k])) begin n_fail++; $display("FAIL tie_comp_pulse[%0d]: got %0d want %0d", k, complete_id, exp_a[k]); end
        end
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== '0) begin n_fail++; $display("FAIL tie_claim_empty: got %0d want 0", claim_id); end
        tick();
        $display("test_priority_tie done");
    endtask

    task automatic test_threshold_enable();
        set_prio(5, 3); enable[5] = 1'b1; threshold = 3;
        pending_set[5] = 1'b1; tick(); tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL thr_equal_irq: got %b want 0", irq); end
        threshold = 2; tick();
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL thr_lower_irq: got %b want 1", irq); end
        enable[5] = 1'b0; tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL en_off_irq: got %b want 0", irq); end
        n_cmp++; if (pending_q[5] !== 1'b1) begin n_fail++; $display("FAIL en_off_pend: got %b want 1", pending_q[5]); end
        enable[5] = 1'b1; tick();
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(5)) begin n_fail++; $display("FAIL thr_claim: got %0d want 5", claim_id); end
        tick();
        complete_req = 1'b1; complete_wr_id = IW'(5); tick();
        n_cmp++; if (complete_id !== IW'(5)) begin n_fail++; $display("FAIL thr_complete: got %0d want 5", complete_id); end
        threshold = 0;
        $display("test_threshold_enable done");
    endtask

    task automatic test_back_to_back();
        pending_set[2] = 1'b1; pending_set[4] = 1'b1; tick(); tick();
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(4)) begin n_fail++; $display("FAIL b2b_first: got %0d want 4", claim_id); end
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_settle_irq: got %b want 0", irq); end
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== '0) begin n_fail++; $display("FAIL b2b_second: got %0d want 0", claim_id); end
        tick();
        n_cmp++; if (pending_q[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_pend2: got %b want 1", pending_q[2]); end
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(2)) begin n_fail++; $display("FAIL b2b_third: got %0d want 2", claim_id); end
        tick();
        complete_req = 1'b1; complete_wr_id = IW'(4); tick();
        complete_req = 1'b1; complete_wr_id = IW'(2); tick();
        n_cmp++; if (complete_id !== IW'(2)) begin n_fail++; $display("FAIL b2b_complete: got %0d want 2", complete_id); end
        $display("test_back_to_back done");
    endtask

    task automatic test_bad_complete();
        int bad_a [3] = '{9, 0, 31};
        pending_set[7] = 1'b1; tick(); tick();
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(7)) begin n_fail++; $display("FAIL bad_setup_claim: got %0d want 7", claim_id); end
        tick();
        for (int k = 0; k < 3; k++) begin
            complete_req = 1'b1; complete_wr_id = IW'(bad_a[k]); tick();
            n_cmp++; if (complete_id !== '0) begin n_fail++; $display("FAIL bad_complete_%0d: got %0d want 0", bad_a[k], complete_id); end
        end
        complete_req = 1'b1; complete_wr_id = IW'(7); tick();
        n_cmp++; if (complete_id !== IW'(7)) begin n_fail++; $display("FAIL bad_still_in_service: got %0d want 7", complete_id); end
        $display("test_bad_complete done");
    endtask

    task automatic test_reset_mid();
        pending_set[2] = 1'b1; pending_set[4] = 1'b1; pending_set[7] = 1'b1;
        tick(); tick();
        claim_req = 1'b1; #1;
        n_cmp++; if (claim_id !== IW'(4)) begin n_fail++; $display("FAIL rmid_claim: got %0d want 4", claim_id); end
        tick(); tick();
        #2; rst_n = 1'b0; claim_req = 1'b1; #1;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rmid_irq: got %b want 0", irq); end
        n_cmp++; if (pending_q !== '0) begin n_fail++; $display("FAIL rmid_pending: got %h want 0", pending_q); end
        n_cmp++; if (claim_id !== '0) begin n_fail++; $display("FAIL rmid_claim_id: got %0d want 0", claim_id); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; claim_req = 1'b0;
        tick(); tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rmid_post_irq: got %b want 0", irq); end
        complete_req = 1'b1; complete_wr_id = IW'(4); tick();
        n_cmp++; if (complete_id !== '0) begin n_fail++; $display("FAIL rmid_stale_complete: got %0d want 0", complete_id); end
        pending_set[2] = 1'b1; tick(); tick();
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rmid_new_irq: got %b want 1", irq); end
        claim_req = 1'b1; tick();
        complete_req = 1'b1; complete_wr_id = IW'(2); tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random(input int n);
        int ids [$];
        for (int it = 0; it < n; it++) begin
            if (it % 25 == 0) begin
                for (int i = 1; i <= NS; i++) set_prio(i, int'($urandom_range(0, 7)));
                enable    = ($urandom | $urandom);
                threshold = PW'($urandom_range(0, 3));
            end
            pending_set  = $urandom & $urandom & $urandom & $urandom;
            claim_req    = ($urandom_range(0, 2) == 0);
            complete_req = ($urandom_range(0, 2) == 0);
            ids.delete();
            for (int i = 1; i <= NS; i++) if (m_insvc[i]) ids.push_back(i);
            if (ids.size() > 0 && $urandom_range(0, 3) != 0)
                complete_wr_id = IW'(ids[$urandom_range(0, ids.size() - 1)]);
            else
                complete_wr_id = IW'($urandom_range(0, 31));
            #1;
            n_cmp++; if (claim_id !== IW'(model_claim())) begin n_fail++; $display("FAIL rnd_claim[%0d]: got %0d want %0d", it, claim_id, model_claim()); end
            tick();
            n_cmp++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq, m_irq); end
            n_cmp++; if (complete_id !== IW'(m_cid)) begin n_fail++; $display("FAIL rnd_complete[%0d]: got %0d want %0d", it, complete_id, m_cid); end
            n_cmp++; if (pending_q !== model_pend_vec()) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %h want %h", it, pending_q, model_pend_vec()); end
        end
        $display("test_random done: %0d cycles", n);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_priority_tie();
        test_threshold_enable();
        test_back_to_back();
        test_bad_complete();
        test_reset_mid();
        test_random(800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
